// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder exposing NUM_REGS byte-strobed registers; one outstanding write and one read, independent paths.
// Optional AXIL_SLV_ADDR_CHECK_EN: out-of-range accesses get SLVERR instead of aliasing modulo NUM_REGS.
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [ADDR_WIDTH-1:0]            awaddr,
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic                             wvalid,
  output logic                             wready,
  output logic [1:0]                       bresp,
  output logic                             bvalid,
  input  logic                             bready,
  input  logic [ADDR_WIDTH-1:0]            araddr,
  input  logic                             arvalid,
  output logic                             arready,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  output logic                             rvalid,
  input  logic                             rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_out,
  output logic                             wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]      wr_idx
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_A, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  aw_hs, w_hs, ar_hs, wr_commit;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [STRB_W-1:0]     cm_strb;
  logic [IDX_W-1:0]      cm_idx, rd_idx;
  logic                  cm_ok, rd_ok;
  logic                  unused_addr_bits;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign cm_idx = cm_addr[ADDR_LSB +: IDX_W];
  assign rd_idx = araddr[ADDR_LSB +: IDX_W];
  assign unused_addr_bits = ^{cm_addr, araddr};

`ifdef AXIL_SLV_ADDR_CHECK_EN
  assign cm_ok = (cm_addr >> (ADDR_LSB + IDX_W)) == '0;
  assign rd_ok = (araddr >> (ADDR_LSB + IDX_W)) == '0;
`else
  assign cm_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  always_ff @(posedge aclk) begin
    if (areset) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_next = WR_RESP;
        else if (aw_hs)    wr_next = WR_WAIT_W;
        else if (w_hs)     wr_next = WR_WAIT_A;
      end
      WR_WAIT_W: if (w_hs)   wr_next = WR_RESP;
      WR_WAIT_A: if (aw_hs)  wr_next = WR_RESP;
      WR_RESP:   if (bready) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase
  end

  // Readies come from state only; reset is the sole input allowed to mask them.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (wr_state)
      WR_IDLE:   begin awready = 1'b1; wready = 1'b1; end
      WR_WAIT_W: wready  = 1'b1;
      WR_WAIT_A: awready = 1'b1;
      WR_RESP:   bvalid  = 1'b1;
      default:   ;
    endcase
    if (areset) begin
      awready = 1'b0;
      wready  = 1'b0;
    end
  end

  // Whichever half arrived earlier comes from the latch, the other from the live bus.
  always_comb begin
    wr_commit = 1'b0;
    cm_addr   = awaddr;
    cm_data   = wdata;
    cm_strb   = wstrb;
    unique case (wr_state)
      WR_IDLE:   wr_commit = aw_hs && w_hs;
      WR_WAIT_W: begin wr_commit = w_hs;  cm_addr = awaddr_q; end
      WR_WAIT_A: begin wr_commit = aw_hs; cm_data = wdata_q; cm_strb = wstrb_q; end
      default:   ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp    <= 2'b00;
      wr_pulse <= 1'b0;
      wr_idx   <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (aw_hs) awaddr_q <= awaddr;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (wr_commit) begin
        bresp <= cm_ok ? 2'b00 : 2'b10;
        if (cm_ok) begin
          wr_pulse <= 1'b1;
          wr_idx   <= cm_idx;
          for (int b = 0; b < STRB_W; b++)
            if (cm_strb[b]) regs[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (ar_hs)  rd_next = RD_DATA;
      RD_DATA: if (rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    arready = (rd_state == RD_IDLE) && !areset;
    rvalid  = (rd_state == RD_DATA);
  end

  // regs[] is sampled before any same-edge write lands, so a colliding read sees the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata <= '0;
      rresp <= 2'b00;
    end else if (ar_hs) begin
      rdata <= rd_ok ? regs[rd_idx] : '0;
      rresp <= rd_ok ? 2'b00 : 2'b10;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Randomised + directed bench for axi_lite_slave_regs: a behavioural register-array model feeds
// expectation queues that an independent monitor drains on every B, R and wr_pulse event.
module tb_axi_lite_slave_regs;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
`ifdef AXIL_SLV_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic [AW-1:0]   awaddr = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [AW-1:0]   araddr = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready = 1'b0;
  logic [NR*DW-1:0] regs_out;
  logic            wr_pulse;
  logic [3:0]      wr_idx;

  axi_lite_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .wr_idx(wr_idx)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mdl [NR];
  logic [1:0]    exp_b_q [$];
  logic [33:0]   exp_r_q [$];
  logic [3:0]    exp_idx_q [$];

  task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic bit in_range(input logic [AW-1:0] a);
    return !CHK || (a < NR * (DW / 8));
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a / (DW / 8)) % NR);
  endfunction

  function automatic logic [NR*DW-1:0] exp_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  function automatic void model_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    int k;
    k = idx_of(a);
    exp_b_q.push_back(in_range(a) ? 2'b00 : 2'b10);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
      exp_idx_q.push_back(4'(k));
    end
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = in_range(a) ? mdl[idx_of(a)] : '0;
    exp_r_q.push_back({(in_range(a) ? 2'b00 : 2'b10), v});
    return v;
  endfunction

  // Monitor: every completed response and every wr_pulse consumes one expectation.
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (bvalid && bready) begin
          if (exp_b_q.size() == 0) unexpected("b_response");
          else check("bresp", bresp, exp_b_q.pop_front());
        end
        if (rvalid && rready) begin
          if (exp_r_q.size() == 0) unexpected("r_response");
          else check("rresp_rdata", {rresp, rdata}, exp_r_q.pop_front());
        end
        if (wr_pulse) begin
          if (exp_idx_q.size() == 0) unexpected("wr_pulse");
          else check("wr_idx", wr_idx, exp_idx_q.pop_front());
        end
      end
    end
  end

  // All drive tasks start and end just after a rising edge.
  task automatic wr_drive(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    int n;
    logic hs;
    bready = (b_dly == 0);
    fork
      begin
        int c;
        logic h;
        repeat (aw_dly) begin @(posedge aclk); #1; end
        awaddr = a; awvalid = 1'b1;
        c = 0;
        do begin @(negedge aclk); h = awready; @(posedge aclk); #1; c++; end while (!h && c < 50);
        if (!h) unexpected("aw_timeout");
        awvalid = 1'b0;
      end
      begin
        int c;
        logic h;
        repeat (w_dly) begin @(posedge aclk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        c = 0;
        do begin @(negedge aclk); h = wready; @(posedge aclk); #1; c++; end while (!h && c < 50);
        if (!h) unexpected("w_timeout");
        wvalid = 1'b0;
      end
    join
    for (int i = 0; i < b_dly; i++) begin
      @(negedge aclk); check("b_hold", {bvalid, bresp}, {1'b1, exp_b_q[0]});
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    n = 0;
    do begin @(negedge aclk); hs = bvalid; @(posedge aclk); #1; n++; end while (!hs && n < 50);
    check("b_latency", n, 1);
    bready = 1'b0;
    check("regs_out", regs_out, exp_flat());
  endtask

  task automatic rd_drive(input logic [AW-1:0] a, input int r_dly, input logic [DW-1:0] v);
    int n;
    logic hs;
    rready = (r_dly == 0);
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); hs = arready; @(posedge aclk); #1; n++; end while (!hs && n < 50);
    if (!hs) unexpected("ar_timeout");
    arvalid = 1'b0;
    for (int i = 0; i < r_dly; i++) begin
      @(negedge aclk); check("r_hold", {rvalid, arready, rdata}, {1'b1, 1'b0, v});
      @(posedge aclk); #1;
    end
    rready = 1'b1;
    n = 0;
    do begin @(negedge aclk); hs = rvalid; @(posedge aclk); #1; n++; end while (!hs && n < 50);
    check("r_latency", n, 1);
    rready = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, input int b_dly);
    model_wr(a, d, s);
    wr_drive(a, d, s, aw_dly, w_dly, b_dly);
  endtask

  task automatic rd(input logic [AW-1:0] a, input int r_dly);
    logic [DW-1:0] v;
    v = model_rd(a);
    rd_drive(a, r_dly, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    logic [AW-1:0] a;
    for (int i = 0; i < NR; i++) mdl[i] = '0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("ready_in_reset", {awready, wready, arready}, 3'b000);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("reset_valids", {bvalid, rvalid, wr_pulse, wr_idx}, '0);
    check("reset_resp_data", {bresp, rresp, rdata}, '0);
    check("reset_regs", regs_out, '0);
    check("ready_after_reset", {awready, wready, arready}, 3'b111);
    @(posedge aclk); #1;

    wr(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    wr(32'h04, 32'hAAAAAAAA, 4'hF, 0, 0, 1);
    wr(32'h04, 32'h12345678, 4'h3, 3, 0, 0);
    check("reg1_partial", regs_out[1*DW +: DW], 32'hAAAA5678);
    rd(32'h08, 4);
    rd(32'h0B, 0);

    // Same-edge write and read of reg3: read must return the pre-write value.
    v = model_rd(32'h0C);
    model_wr(32'h0C, 32'h1, 4'hF);
    fork
      wr_drive(32'h0C, 32'h1, 4'hF, 0, 0, 0);
      rd_drive(32'h0C, 0, v);
    join
    rd(32'h0C, 0);

    wr(32'h100, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
    rd(32'h100, 0);
    wr(32'h14, 32'hCAFEF00D, 4'h0, 0, 2, 0);
    rd(32'h14, 1);

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom_range(NR * 4, 32'hFFF);
      else                           a = $urandom_range(0, NR * 4 - 1);
      if ($urandom_range(0, 2) == 0) rd(a, $urandom_range(0, 3));
      else wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Abandon a write parked in WR_WAIT_W with a reset.
    wr(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 0);
    awaddr = 32'h10; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    check("wait_w_readies", {awready, wready}, 2'b01);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(negedge aclk);
    check("ready_mid_reset", {awready, wready, arready}, 3'b000);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    @(negedge aclk);
    check("post_reset_bvalid", {bvalid, wr_pulse}, 2'b00);
    check("post_reset_regs", regs_out, exp_flat());
    @(posedge aclk); #1;
    wr(32'h10, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
    rd(32'h10, 0);

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("pending_b", exp_b_q.size(), 0);
    check("pending_r", exp_r_q.size(), 0);
    check("pending_pulse", exp_idx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
